// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake plus instruction-memory write port.
// slave is the loader side; master is the host/memory side.
interface program_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_addr, wr_data, wr_en
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a little-endian byte stream into instruction
// words, writes them from word 0 and holds the core until the image is in.
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [15:0]     words_loaded
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] BYTE   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

    logic [2:0]            state;
    logic [15:0]           len;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] word_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [15:0]           n_full;
    logic [15:0]           wl_inc;
    logic                  xfer;

    assign bus.byte_ready = (state == LEN_LO) || (state == LEN_HI)
                         || (state == BYTE);
    assign bus.wr_en      = (state == WRITE);
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;

    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = (state != DONE);

    assign xfer   = bus.byte_valid && bus.byte_ready;
    assign n_full = {bus.byte_in[7:0], len[7:0]};
    assign wl_inc = words_loaded + 16'd1;

    always_comb begin
        word_next = word;
        word_next[byte_idx*BYTE_WIDTH +: BYTE_WIDTH] = bus.byte_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= '0;
            byte_idx     <= '0;
            word         <= '0;
            words_loaded <= '0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_LO;
                        words_loaded <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.byte_in[7:0];
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.byte_in[7:0];
                        byte_idx  <= '0;
                        if (n_full == 16'd0)
                            state <= DONE;
                        else if ({1'b0, n_full} > DEPTH)
                            state <= ERR;
                        else
                            state <= BYTE;
                    end
                end
                BYTE: begin
                    if (xfer) begin
                        word     <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        // Latch the full word and its address for the write cycle
                        if (byte_idx == 2'd3) begin
                            data_q <= word_next;
                            addr_q <= ADDR_WIDTH'({words_loaded, 2'b00});
                            state  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= wl_inc;
                    state        <= (wl_inc == len) ? DONE : BYTE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
